// File: rtl/ultrasonic_tx.sv
// rtl/ultrasonic_tx.sv - ultrasonic ranging transmitter: drive burst, ring-down blanking, echo listen, time of flight
// Every output is a flop; the next output values are decided on the same edge as the state change.
module ultrasonic_tx #(
    parameter int HALF_PERIOD  = 1250,
    parameter int BURST_PULSES = 8,
    parameter int BLANK_CLKS   = 100000,
    parameter int LISTEN_CLKS  = 2000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        trigger,
    input  logic        echo_detected,
    output logic        tx_out,
    output logic        tx_active,
    output logic        listen_window,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [23:0] tof_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BURST  = 2'd1;
    localparam logic [1:0] S_BLANK  = 2'd2;
    localparam logic [1:0] S_LISTEN = 2'd3;

    localparam logic [31:0] HALF_LAST   = 32'(HALF_PERIOD - 1);
    localparam logic [31:0] PULSE_LAST  = 32'(BURST_PULSES - 1);
    localparam logic [31:0] BLANK_LAST  = 32'(BLANK_CLKS - 1);
    localparam logic [31:0] LISTEN_LAST = 32'(LISTEN_CLKS - 1);
    localparam logic [23:0] TOF_MAX     = 24'hFFFFFF;

    logic [1:0]  state;
    logic [31:0] half_cnt;
    logic [31:0] pulse_cnt;
    logic [31:0] win_cnt;
    logic [23:0] tof_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= S_IDLE;
            half_cnt      <= '0;
            pulse_cnt     <= '0;
            win_cnt       <= '0;
            tof_cnt       <= '0;
            tx_out        <= 1'b0;
            tx_active     <= 1'b0;
            listen_window <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            tof_count     <= '0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && tof_cnt != TOF_MAX) begin
                tof_cnt <= tof_cnt + 24'd1;
            end
            case (state)
                S_IDLE: begin
                    // the done cycle sits in IDLE but still refuses a new trigger
                    if (trigger && !done) begin
                        state     <= S_BURST;
                        half_cnt  <= '0;
                        pulse_cnt <= '0;
                        tof_cnt   <= '0;
                        tx_out    <= 1'b1;
                        tx_active <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (tx_out) begin
                            tx_out <= 1'b0;
                        end else if (pulse_cnt == PULSE_LAST) begin
                            state     <= S_BLANK;
                            tx_active <= 1'b0;
                            win_cnt   <= '0;
                        end else begin
                            pulse_cnt <= pulse_cnt + 32'd1;
                            tx_out    <= 1'b1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 32'd1;
                    end
                end
                S_BLANK: begin
                    if (win_cnt == BLANK_LAST) begin
                        state         <= S_LISTEN;
                        win_cnt       <= '0;
                        listen_window <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt + 32'd1;
                    end
                end
                S_LISTEN: begin
                    // an echo on the final window cycle wins over the timeout
                    if (echo_detected) begin
                        state         <= S_IDLE;
                        listen_window <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        timeout       <= 1'b0;
                        tof_count     <= tof_cnt;
                    end else if (win_cnt == LISTEN_LAST) begin
                        state         <= S_IDLE;
                        listen_window <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        timeout       <= 1'b1;
                        tof_count     <= TOF_MAX;
                    end else begin
                        win_cnt <= win_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
